// File: rtl/word_2_data.sv
// word_2_data: receive-side deserializer for the 32-bit word stream.
// Undoes the per-word byte reversal, packs up to N words into an N*32-bit
// frame and presents it with a one-cycle o_valid pulse and a byte length.
// Optional gap watchdog: define WORD2DATA_TIMEOUT_EN to build it; otherwise
// o_err_timeout is held at 0 and inter-word gaps wait indefinitely.
module word_2_data #(
    parameter int N       = 399,
    parameter int TIMEOUT = 64,
    parameter int LEN_W   = $clog2(4*N+1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_data,
    input  logic              i_valid,
    input  logic              i_last,
    input  logic [1:0]        i_last_bytes,
    output logic [N*32-1:0]   o_data,
    output logic              o_valid,
    output logic [LEN_W-1:0]  o_len_bytes,
    output logic              o_err_ovf,
    output logic              o_err_timeout,
    output logic              o_busy
);

    localparam int               CNT_W    = $clog2(N+1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject nonsensical configurations at elaboration time.
    if (N < 1 || TIMEOUT < 1) begin : g_param_check
        $error("word_2_data: N and TIMEOUT must both be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    // Assembly buffer: kept separate from o_data so an aborted frame never
    // disturbs the last good frame a consumer may still be reading.
    logic [N*32-1:0]    frame;
    logic [N*32-1:0]    frame_nxt;
    logic [31:0]        wr_word;
    logic               room;
    int                 wr_idx;

`ifdef WORD2DATA_TIMEOUT_EN
    localparam int               GAP_W    = $clog2(TIMEOUT+1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT-1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    logic [GAP_W-1:0]   gap;
`endif

    // Byte-reverse a wire word; for a final word keep only nb bytes taken
    // from the top of the wire word (nb = 0 is a padding word -> all zero).
    function automatic logic [31:0] map_word(input logic [31:0] d,
                                             input logic        last,
                                             input logic [1:0]  nb);
        logic [31:0] rev;
        rev = {d[7:0], d[15:8], d[23:16], d[31:24]};
        if (!last) begin
            return rev;
        end
        case (nb)
            2'd1:    return {24'h0, rev[7:0]};
            2'd2:    return {16'h0, rev[15:0]};
            2'd3:    return {8'h0,  rev[23:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Frame byte count: four bytes per full word plus the tail bytes.
    function automatic logic [LEN_W-1:0] frame_len(input logic [CNT_W-1:0] words,
                                                   input logic [1:0]       nb);
        return (LEN_W'(words) << 2) + LEN_W'(nb);
    endfunction

    // Next content of the assembly buffer if the current word is stored.
    always_comb begin
        room    = (count < CNT_FULL);
        wr_word = map_word(i_data, i_last, i_last_bytes);
        wr_idx  = int'(count);
        frame_nxt = frame;
        if (state == S_IDLE) begin
            frame_nxt        = '0;
            frame_nxt[31:0]  = wr_word;
        end else if (room) begin
            frame_nxt[wr_idx*32 +: 32] = wr_word;
        end
    end

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            frame         <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_len_bytes   <= '0;
            o_err_ovf     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_busy        <= 1'b0;
`ifdef WORD2DATA_TIMEOUT_EN
            gap           <= '0;
`endif
        end else begin
            o_valid       <= 1'b0;
            o_err_ovf     <= 1'b0;
            o_err_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        frame <= frame_nxt;
`ifdef WORD2DATA_TIMEOUT_EN
                        gap   <= '0;
`endif
                        if (i_last) begin
                            // Single-word frame completes immediately.
                            o_data      <= frame_nxt;
                            o_valid     <= 1'b1;
                            o_len_bytes <= frame_len('0, i_last_bytes);
                            count       <= '0;
                        end else begin
                            count  <= CNT_ONE;
                            state  <= S_COLLECT;
                            o_busy <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (i_valid) begin
`ifdef WORD2DATA_TIMEOUT_EN
                        gap <= '0;
`endif
                        if (!i_last) begin
                            if (room) begin
                                frame <= frame_nxt;
                                count <= count + CNT_ONE;
                            end else begin
                                o_err_ovf <= 1'b1;
                                state     <= S_DROP;
                            end
                        end else if (room) begin
                            frame       <= frame_nxt;
                            o_data      <= frame_nxt;
                            o_valid     <= 1'b1;
                            o_len_bytes <= frame_len(count, i_last_bytes);
                            count       <= '0;
                            state       <= S_IDLE;
                            o_busy      <= 1'b0;
                        end else if (i_last_bytes == 2'd0) begin
                            // Full frame closed by a padding word.
                            o_data      <= frame;
                            o_valid     <= 1'b1;
                            o_len_bytes <= frame_len(CNT_FULL, 2'd0);
                            count       <= '0;
                            state       <= S_IDLE;
                            o_busy      <= 1'b0;
                        end else begin
                            // Real data beyond capacity: abandon the frame.
                            o_err_ovf <= 1'b1;
                            count     <= '0;
                            state     <= S_IDLE;
                            o_busy    <= 1'b0;
                        end
                    end
`ifdef WORD2DATA_TIMEOUT_EN
                    else if (gap == GAP_LAST) begin
                        o_err_timeout <= 1'b1;
                        gap           <= '0;
                        count         <= '0;
                        state         <= S_IDLE;
                        o_busy        <= 1'b0;
                    end else begin
                        gap <= gap + GAP_ONE;
                    end
`endif
                end

                S_DROP: begin
                    if (i_valid) begin
`ifdef WORD2DATA_TIMEOUT_EN
                        gap <= '0;
`endif
                        if (i_last) begin
                            count  <= '0;
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
`ifdef WORD2DATA_TIMEOUT_EN
                    else if (gap == GAP_LAST) begin
                        o_err_timeout <= 1'b1;
                        gap           <= '0;
                        count         <= '0;
                        state         <= S_IDLE;
                        o_busy        <= 1'b0;
                    end else begin
                        gap <= gap + GAP_ONE;
                    end
`endif
                end

                default: begin
                    count  <= '0;
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_2_data.sv
// tb_word_2_data: directed-vector bench for word_2_data with N=4, TIMEOUT=8.
module tb_word_2_data;

    localparam int N     = 4;
    localparam int LEN_W = $clog2(4*N+1);

    logic             clk;
    logic             rst_n;
    logic [31:0]      i_data;
    logic             i_valid;
    logic             i_last;
    logic [1:0]       i_last_bytes;
    logic [N*32-1:0]  o_data;
    logic             o_valid;
    logic [LEN_W-1:0] o_len_bytes;
    logic             o_err_ovf;
    logic             o_err_timeout;
    logic             o_busy;

    int n_chk = 0;
    int n_err = 0;

    logic [127:0] f1, f2, f4, f5, f6, f7;

    word_2_data #(.N(N), .TIMEOUT(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_last        (i_last),
        .i_last_bytes  (i_last_bytes),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_len_bytes   (o_len_bytes),
        .o_err_ovf     (o_err_ovf),
        .o_err_timeout (o_err_timeout),
        .o_busy        (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one word for one clock; returns 1 time unit after the edge.
    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb);
        i_data       = d;
        i_valid      = 1'b1;
        i_last       = last;
        i_last_bytes = nb;
        @(posedge clk);
        #1;
        i_data       = '0;
        i_valid      = 1'b0;
        i_last       = 1'b0;
        i_last_bytes = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        f1 = {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
        f2 = {32'h00000000, 32'h0000BBAA, 32'hEFCDAB89, 32'h67452301};
        f4 = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00030201};
        f5 = {32'h00000000, 32'h00000000, 32'h00000055, 32'hD4C3B2A1};
        f6 = {32'h00000000, 32'h00000000, 32'h0000FECA, 32'h11111111};
        f7 = {32'h3C2D1E0F, 32'hF0DEBC9A, 32'h78563412, 32'hC3D2E1F0};

        rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_last = 1'b0; i_last_bytes = '0;
        idle(3);
        chk("rst_data",  o_data, '0);
        chk("rst_valid", o_valid, 0);
        chk("rst_len",   o_len_bytes, 0);
        chk("rst_ovf",   o_err_ovf, 0);
        chk("rst_to",    o_err_timeout, 0);
        chk("rst_busy",  o_busy, 0);
        rst_n = 1'b1;
        idle(1);

        // Full frame closed by a padding word.
        send(32'h11223344, 1'b0, 2'd0);
        chk("f1_busy", o_busy, 1);
        send(32'h55667788, 1'b0, 2'd0);
        send(32'h99AABBCC, 1'b0, 2'd0);
        send(32'hDDEEFF00, 1'b0, 2'd0);
        chk("f1_novalid", o_valid, 0);
        send(32'h12345678, 1'b1, 2'd0);
        chk("f1_valid", o_valid, 1);
        chk("f1_len",   o_len_bytes, 16);
        chk("f1_data",  o_data, f1);
        chk("f1_ovf",   o_err_ovf, 0);
        idle(1);
        chk("f1_pulse", o_valid, 0);
        chk("f1_idle",  o_busy, 0);

        // Partial final word.
        send(32'h01234567, 1'b0, 2'd0);
        send(32'h89ABCDEF, 1'b0, 2'd0);
        send(32'hAABBCCDD, 1'b1, 2'd2);
        chk("f2_valid", o_valid, 1);
        chk("f2_len",   o_len_bytes, 10);
        chk("f2_data",  o_data, f2);
        idle(2);

        // Six words without last: overflow on the fifth, then drop.
        for (int i = 0; i < 6; i++) begin
            send(32'h10000000 + 32'(i), 1'b0, 2'd0);
            chk("ov_novalid", o_valid, 0);
            chk("ov_ovf", o_err_ovf, (i == 4) ? 1 : 0);
            chk("ov_busy", o_busy, 1);
        end
        send(32'hDEADBEEF, 1'b1, 2'd3);
        chk("ov_end_valid", o_valid, 0);
        chk("ov_end_ovf",   o_err_ovf, 0);
        chk("ov_end_busy",  o_busy, 0);
        chk("ov_keep_data", o_data, f2);
        idle(1);

        // Real data one word past capacity on the last word.
        for (int i = 0; i < 4; i++) begin
            send(32'h20000000 + 32'(i), 1'b0, 2'd0);
        end
        send(32'h30303030, 1'b1, 2'd1);
        chk("ovl_ovf",   o_err_ovf, 1);
        chk("ovl_valid", o_valid, 0);
        chk("ovl_busy",  o_busy, 0);
        chk("ovl_data",  o_data, f2);
        idle(1);

        // Single-word frame, then a back-to-back frame on the o_valid cycle.
        send(32'h01020304, 1'b1, 2'd3);
        chk("f4_valid", o_valid, 1);
        chk("f4_len",   o_len_bytes, 3);
        chk("f4_data",  o_data, f4);
        send(32'hA1B2C3D4, 1'b0, 2'd0);
        chk("f5_start_valid", o_valid, 0);
        chk("f5_start_busy",  o_busy, 1);
        send(32'h55667788, 1'b1, 2'd1);
        chk("f5_valid", o_valid, 1);
        chk("f5_len",   o_len_bytes, 5);
        chk("f5_data",  o_data, f5);
        idle(1);

        // Gap inside a frame that stays within any watchdog limit.
        send(32'h11111111, 1'b0, 2'd0);
`ifdef WORD2DATA_TIMEOUT_EN
        idle(7);
`else
        idle(20);
`endif
        chk("gap_to",   o_err_timeout, 0);
        chk("gap_busy", o_busy, 1);
        send(32'hCAFEBABE, 1'b1, 2'd2);
        chk("f6_valid", o_valid, 1);
        chk("f6_len",   o_len_bytes, 6);
        chk("f6_data",  o_data, f6);
        idle(1);

`ifdef WORD2DATA_TIMEOUT_EN
        // One word then a long gap: abort after eight idle cycles.
        send(32'h44444444, 1'b0, 2'd0);
        idle(7);
        chk("to_early", o_err_timeout, 0);
        chk("to_early_busy", o_busy, 1);
        idle(1);
        chk("to_pulse", o_err_timeout, 1);
        chk("to_busy",  o_busy, 0);
        chk("to_valid", o_valid, 0);
        idle(1);
        chk("to_pulse_end", o_err_timeout, 0);
`endif

        // Reset in the middle of a frame discards it.
        send(32'hABABABAB, 1'b0, 2'd0);
        send(32'hCDCDCDCD, 1'b0, 2'd0);
        rst_n = 1'b0;
        #2;
        chk("mr_busy",  o_busy, 0);
        chk("mr_data",  o_data, '0);
        chk("mr_valid", o_valid, 0);
        rst_n = 1'b1;
        send(32'hF0E1D2C3, 1'b0, 2'd0);
        chk("mr_f7_novalid", o_valid, 0);
        send(32'h12345678, 1'b0, 2'd0);
        send(32'h9ABCDEF0, 1'b0, 2'd0);
        send(32'h0F1E2D3C, 1'b0, 2'd0);
        chk("mr_f7_novalid2", o_valid, 0);
        send(32'h00000000, 1'b1, 2'd0);
        chk("f7_valid", o_valid, 1);
        chk("f7_len",   o_len_bytes, 16);
        chk("f7_data",  o_data, f7);
        idle(1);
        chk("f7_pulse",   o_valid, 0);
        chk("final_to",   o_err_timeout, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/word_2_data.md
Name: word_2_data

Overview:
- Receive-side deserializer for the 32-bit word stream produced by the frame serializer. Accepts byte-ordered words with valid/last/last_bytes, undoes the per-word byte reversal and packs up to N words into one wide N*32-bit frame register.
- Presents the frame with a one-cycle o_valid pulse and a byte length.
- Sits between the word-stream link and wide-bus consumers.

Parameters:
- N, 399, maximum number of full 32-bit data words per frame.
- TIMEOUT, 64, idle cycles allowed between words inside a frame before abort (used only with the optional feature).
- LEN_W, $clog2(4*N+1), width of o_len_bytes (derived; do not override).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  32  stream word, first byte on wire in [31:24].
- i_valid  in  1  word qualifier; no backpressure, a word is accepted whenever i_valid=1.
- i_last  in  1  final word of frame, qualified by i_valid.
- i_last_bytes  in  2  valid bytes in the final word (0..3); 0 = padding word, discarded; ignored when i_last=0.
- o_data  out  N*32  assembled frame; word k at [k*32 +: 32].
- o_valid  out  1  one-cycle pulse when the frame is complete.
- o_len_bytes  out  LEN_W  frame byte count, valid with o_valid.
- o_err_ovf  out  1  one-cycle pulse when a frame exceeds capacity.
- o_err_timeout  out  1  one-cycle pulse when a frame is aborted by the gap watchdog.
- o_busy  out  1  high while in COLLECT or DROP.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State returns to IDLE; word counter = 0.
  - o_data = 0, o_valid = 0, o_len_bytes = 0, all error outputs = 0, o_busy = 0.
  - Asserting reset mid-frame discards the partial frame; no pulse is produced.
- Byte mapping:
  - Stored word = byte-reverse(i_data), i.e. i_data[31:24] lands in bits [7:0].
  - Partial last word with i_last_bytes = b (1..3): keep the b bytes taken from the top of i_data; zero the remaining high bytes of the stored word.
  - Example: i_data = 32'hAABBCCDD, b = 2 → stored 32'h0000BBAA.
- State machine IDLE / COLLECT / DROP:
  - IDLE, i_valid=1:
    - Clear the whole frame register, write word 0, count = 1.
    - If i_last is also set, complete immediately (single-word frame).
    - Otherwise go to COLLECT.
  - COLLECT, i_valid=1, i_last=0:
    - If count < N: write word[count], count++.
    - If count == N: overflow → o_err_ovf pulse, go to DROP.
  - COLLECT, i_valid=1, i_last=1:
    - count < N: write the (partial) word at [count].
    - count == N with i_last_bytes = 0: padding word, accepted and discarded.
    - count == N with i_last_bytes != 0: o_err_ovf pulse, no o_valid, go to IDLE.
  - DROP: discard words until one with i_valid & i_last, then go to IDLE. o_data keeps the previous good frame.
- Completion:
  - o_valid and o_len_bytes are registered and assert on the cycle after the last word is accepted (latency 1).
  - o_len_bytes = 4*(full words) + i_last_bytes.
  - o_data is updated only by the frame being assembled. Consumers must sample it on o_valid; it holds until the next frame starts.
- Back-to-back frames: a word with i_valid=1 on the cycle o_valid is high starts a new frame from IDLE.
- Gaps: i_valid=0 cycles inside a frame are legal. Without the watchdog they wait indefinitely.

Optional Feature:
- Macro: WORD2DATA_TIMEOUT_EN.
- Defined:
  - A gap counter in COLLECT/DROP resets on each accepted word and increments on i_valid=0.
  - Reaching TIMEOUT → o_err_timeout pulse and return to IDLE, no o_valid.
  - A word arriving on the timeout cycle is treated as the start of a new frame.
- Undefined: no counter is built; o_err_timeout is tied to 0.

Test Plan (N=4 unless noted):
- Words 11223344, 55667788, 99AABBCC, DDEEFF00, then padding with last=1, last_bytes=0 → o_valid 1 cycle after padding.
  - o_data words 0..3 = 44332211, 88776655, CCBBAA99, 00FFEEDD.
  - o_len_bytes = 16.
- 2 words, then 3rd word AABBCCDD with last=1, last_bytes=2 → word2 = 0000BBAA, word3 = 0, o_len_bytes = 10.
- 6 words with no last, then last → o_err_ovf pulse when the 5th word arrives; o_valid never asserts; previous o_data unchanged; next frame received correctly.
- Single word 01020304 with last=1, last_bytes=3 → o_valid next cycle, word0 = 00030201, o_len_bytes = 3.
- i_rst_n dropped after 2 words, released, then a full frame sent → only the second frame pulses o_valid, with correct data.
- With WORD2DATA_TIMEOUT_EN and TIMEOUT=8: 1 word followed by a 9-cycle gap → o_err_timeout pulse after 8 idle cycles, state IDLE, o_busy=0.
